serial_byte_rx: RTL and testbench
=================================

Name: serial_byte_rx

Overview:
- Downstream companion of the 8-bit parallel-load, left-shift (MSB-first) serial transmitter.
- Samples the serial bitstream it produces and reassembles MSB-first bits into parallel words.
- Frame input marks the MSB so the receiver aligns to word boundaries.
- Presents each completed word through a valid/ready holding register with a sticky overrun flag.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- REQ_FRAME, 1, 1 = discard bits after reset until the first frame-marked bit; 0 = start assembling immediately after reset.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock; asynchronous, active-low.
- sin  input  1  serial data bit, MSB first.
- sin_valid  input  1  qualifies sin; one bit is consumed per clock with sin_valid=1.
- frame  input  1  sampled only when sin_valid=1; the bit qualified with frame=1 is the MSB of a new word.
- dout  output  WIDTH  assembled word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout on a clock where dout_valid=1 and dout_ready=1.
- overrun  output  1  sticky; a completed word was dropped.
- clr_ovr  input  1  synchronous clear of overrun.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Internal: shreg=0, bit counter cnt=0, state=HUNT if REQ_FRAME=1, else RECV.
  - Outputs: dout=0, dout_valid=0, overrun=0.
  - Reset mid-word discards the partial word.
- States:
  - HUNT: bits with sin_valid=1 and frame=0 are ignored. sin_valid=1 with frame=1 loads the bit as the MSB, sets cnt=1, and moves to RECV.
  - RECV:
    - sin_valid=1, frame=0: shreg <= {shreg[WIDTH-2:0], sin}, cnt++.
    - sin_valid=1, frame=1: realign. Discard the partial word, take sin as the MSB, set cnt=1. No overrun is raised.
    - sin_valid=0: hold all state. Gaps between bits of any length are legal.
- Word completion:
  - A word completes when sin_valid=1, frame=0 and cnt=WIDTH-1.
  - Completed word = {shreg[WIDTH-2:0], sin}; cnt returns to 0 and the state stays RECV.
  - A frame=1 bit never completes a word.
- Latency: dout and dout_valid update on the same rising edge that samples the last bit. They are visible the cycle after that bit is presented.
- Handshake, evaluated at each edge:
  - dout_valid=1 and dout_ready=1 with no completion: dout_valid -> 0, dout holds its value.
  - Completion with dout_valid=0: load dout, dout_valid -> 1.
  - Completion with dout_valid=1 and dout_ready=1: load the new word, dout_valid stays 1, no overrun.
  - Completion with dout_valid=1 and dout_ready=0: drop the new word, dout unchanged, overrun -> 1.
  - dout_ready while dout_valid=0 is ignored.
- Overrun:
  - clr_ovr=1 clears overrun at the next edge.
  - A simultaneous new overrun event wins; overrun stays 1.
- Width rules:
  - cnt is $clog2(WIDTH) bits and must never wrap past WIDTH-1.
  - dout is unchanged except when a word is loaded.

Test Plan:
- REQ_FRAME=1; after reset send 1,0,1 without frame, then 0xA5 MSB-first with frame on the first bit, ready=1 -> the first three bits are ignored, dout=0xA5 and dout_valid=1 one cycle after the last bit, overrun=0.
- Send 0xC3 with random 0-3 cycle sin_valid gaps between bits -> dout=0xC3, single-cycle dout_valid pulse with ready=1.
- Send 3 bits of 0xFF, then a frame-marked 0x3C -> dout=0x3C only, no partial word emitted, overrun=0.
- ready=0; send 0x11 then 0x22 back-to-back -> dout stays 0x11, dout_valid=1, overrun=1. Then clr_ovr=1 -> overrun=0. Then ready=1 -> dout_valid=0.
- Hold 0x11 valid, raise ready on the exact edge where 0x22's last bit is sampled -> dout=0x22, dout_valid stays 1, overrun=0. Also assert clr_ovr on an overrun edge -> overrun=1.
- After 4 bits of a word, pulse rst_n=0 mid-cycle -> dout=0, dout_valid=0, overrun=0 immediately. The next frame-marked 0x5A is received correctly.

Source files
------------

// File: rtl/serial_byte_rx.sv
// serial_byte_rx: reassembles an MSB-first serial bitstream into WIDTH-bit words,
// aligned by a frame marker, and presents them through a valid/ready holding
// register with a sticky overrun flag.
module serial_byte_rx #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          REQ_FRAME = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             frame,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  input  logic             clr_ovr
);

  localparam int unsigned    CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam state_t RST_STATE = REQ_FRAME ? HUNT : RECV;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             done_c;
  logic [WIDTH-1:0] word_c;

  // State, shift register and bit counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_STATE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: hunt for the frame marker, then shift bits in and flag word completion
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    done_c    = 1'b0;
    word_c    = {shreg[WIDTH-2:0], sin};
    unique case (state)
      HUNT: begin
        if (sin_valid && frame) begin
          shreg_nxt = {{(WIDTH-1){1'b0}}, sin};
          cnt_nxt   = CNT_W'(1);
          state_nxt = RECV;
        end
      end
      RECV: begin
        if (sin_valid) begin
          if (frame) begin
            // Realign: the partial word is discarded silently
            shreg_nxt = {{(WIDTH-1){1'b0}}, sin};
            cnt_nxt   = CNT_W'(1);
          end else if (cnt == LAST) begin
            done_c    = 1'b1;
            shreg_nxt = word_c;
            cnt_nxt   = '0;
          end else begin
            shreg_nxt = word_c;
            cnt_nxt   = cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = RST_STATE;
    endcase
  end

  // Output holding register with valid/ready handshake and sticky overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (done_c) begin
        if (!dout_valid || dout_ready) begin
          dout       <= word_c;
          dout_valid <= 1'b1;
        end
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
      // A new drop event takes priority over the clear request
      if (done_c && dout_valid && !dout_ready) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_byte_rx.sv
// Bench for serial_byte_rx: directed scenarios plus a random bitstream, all
// compared against a queue-based word assembly model.
module tb_serial_byte_rx;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         sin;
  logic         sin_valid;
  logic         frame;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         overrun;
  logic         clr_ovr;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit           q[$];
  bit           aligned;
  logic [W-1:0] m_dout;
  logic         m_valid;
  logic         m_ovr;

  serial_byte_rx #(.WIDTH(W), .REQ_FRAME(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .sin_valid (sin_valid),
    .frame     (frame),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .overrun   (overrun),
    .clr_ovr   (clr_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    aligned = 1'b0;
    m_dout  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // Advance one clock: update the model from the current inputs, then compare
  task automatic tick();
    bit           done;
    bit           ovr_evt;
    logic [W-1:0] word;
    done    = 1'b0;
    ovr_evt = 1'b0;
    word    = '0;
    if (sin_valid) begin
      if (frame) begin
        q.delete();
        q.push_back(sin);
        aligned = 1'b1;
      end else if (aligned) begin
        q.push_back(sin);
        if (q.size() == W) begin
          foreach (q[i]) word = (word << 1) | W'(q[i]);
          done = 1'b1;
          q.delete();
        end
      end
    end
    if (done) begin
      if (!m_valid || dout_ready) begin
        m_dout  = word;
        m_valid = 1'b1;
      end else begin
        ovr_evt = 1'b1;
      end
    end else if (m_valid && dout_ready) begin
      m_valid = 1'b0;
    end
    if (ovr_evt) m_ovr = 1'b1;
    else if (clr_ovr) m_ovr = 1'b0;

    @(posedge clk);
    #1;
    chk("model_dout", 32'(dout), 32'(m_dout));
    chk("model_valid", 32'(dout_valid), 32'(m_valid));
    chk("model_ovr", 32'(overrun), 32'(m_ovr));
  endtask

  // Send bits val[hi] down to val[lo], frame on the first one if requested
  task automatic send_bits(input logic [W-1:0] val, input int hi, input int lo,
                           input int max_gap, input bit frame_first);
    for (int i = hi; i >= lo; i--) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      sin_valid = 1'b0;
      frame     = 1'b0;
      for (int g = 0; g < gap; g++) tick();
      sin       = val[i];
      frame     = frame_first && (i == hi);
      sin_valid = 1'b1;
      tick();
    end
    sin_valid = 1'b0;
    frame     = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] val, input int max_gap);
    send_bits(val, W - 1, 0, max_gap, 1'b1);
  endtask

  initial begin
    rst_n      = 1'b0;
    sin        = 1'b0;
    sin_valid  = 1'b0;
    frame      = 1'b0;
    dout_ready = 1'b1;
    clr_ovr    = 1'b0;
    model_reset();
    #12;
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_valid", 32'(dout_valid), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    rst_n = 1'b1;

    // Unframed bits after reset are ignored, then a framed 0xA5
    sin_valid = 1'b1;
    sin = 1'b1; tick();
    sin = 1'b0; tick();
    sin = 1'b1; tick();
    sin_valid = 1'b0;
    chk("hunt_no_word", 32'(dout_valid), 32'h0);
    send_word(8'hA5, 0);
    chk("a5_dout", 32'(dout), 32'hA5);
    chk("a5_valid", 32'(dout_valid), 32'h1);
    chk("a5_ovr", 32'(overrun), 32'h0);
    tick();
    chk("a5_consumed", 32'(dout_valid), 32'h0);

    // Gapped word yields a single-cycle valid pulse
    send_word(8'hC3, 3);
    chk("c3_dout", 32'(dout), 32'hC3);
    chk("c3_valid", 32'(dout_valid), 32'h1);
    tick();
    chk("c3_pulse", 32'(dout_valid), 32'h0);

    // Partial word abandoned by realignment
    send_bits(8'hFF, 7, 5, 0, 1'b1);
    send_word(8'h3C, 0);
    chk("3c_dout", 32'(dout), 32'h3C);
    chk("3c_ovr", 32'(overrun), 32'h0);
    tick();

    // Overrun with consumer stalled, then clear, then drain
    dout_ready = 1'b0;
    send_word(8'h11, 0);
    send_word(8'h22, 0);
    chk("ovr_dout", 32'(dout), 32'h11);
    chk("ovr_valid", 32'(dout_valid), 32'h1);
    chk("ovr_flag", 32'(overrun), 32'h1);
    clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'h0);
    dout_ready = 1'b1; tick();
    chk("ovr_drained", 32'(dout_valid), 32'h0);

    // Ready arrives on the completing edge: replace without overrun
    dout_ready = 1'b0;
    send_word(8'h11, 0);
    send_bits(8'h22, 7, 1, 0, 1'b1);
    dout_ready = 1'b1;
    send_bits(8'h22, 0, 0, 0, 1'b0);
    dout_ready = 1'b0;
    chk("swap_dout", 32'(dout), 32'h22);
    chk("swap_valid", 32'(dout_valid), 32'h1);
    chk("swap_ovr", 32'(overrun), 32'h0);

    // Clear coinciding with a new overrun: overrun wins
    send_bits(8'h33, 7, 1, 0, 1'b1);
    clr_ovr = 1'b1;
    send_bits(8'h33, 0, 0, 0, 1'b0);
    clr_ovr = 1'b0;
    chk("clr_vs_ovr", 32'(overrun), 32'h1);
    chk("clr_vs_ovr_dout", 32'(dout), 32'h22);

    // Asynchronous reset in the middle of a word
    dout_ready = 1'b1;
    send_bits(8'h96, 7, 4, 0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_dout", 32'(dout), 32'h0);
    chk("arst_valid", 32'(dout_valid), 32'h0);
    chk("arst_ovr", 32'(overrun), 32'h0);
    #1 rst_n = 1'b1;
    send_word(8'h5A, 0);
    chk("5a_dout", 32'(dout), 32'h5A);
    chk("5a_valid", 32'(dout_valid), 32'h1);

    // Random bitstream with random frames, readiness and clears
    for (int c = 0; c < 800; c++) begin
      sin_valid  = ($urandom_range(0, 3) != 0);
      sin        = 1'($urandom);
      frame      = ($urandom_range(0, 11) == 0);
      dout_ready = ($urandom_range(0, 2) != 0);
      clr_ovr    = ($urandom_range(0, 9) == 0);
      tick();
    end
    sin_valid = 1'b0;
    frame     = 1'b0;
    clr_ovr   = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
